// File: rtl/alu_pkg.sv
// Shared ALU command encodings and arbiter state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND      = 4'h0;
  localparam logic [3:0] ALU_OR       = 4'h1;
  localparam logic [3:0] ALU_XOR      = 4'h2;
  localparam logic [3:0] ALU_NOT      = 4'h3;
  localparam logic [3:0] ALU_UADD     = 4'h4;
  localparam logic [3:0] ALU_SADD     = 4'h5;
  localparam logic [3:0] ALU_LAST_CMD = 4'h5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and response channels of the shared-ALU arbiter.
interface alu_arbiter_if #(
  parameter int SIZE = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [3:0]        req0_command;
  logic [SIZE-1:0]   req0_a;
  logic [SIZE-1:0]   req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [3:0]        req1_command;
  logic [SIZE-1:0]   req1_a;
  logic [SIZE-1:0]   req1_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [2*SIZE-1:0] rsp_result;
  logic              rsp_overflow;
  logic              rsp_error;
  logic              busy;

  modport slave (
    input  req0_valid, req0_command, req0_a, req0_b,
    input  req1_valid, req1_command, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_error, busy
  );

  modport master (
    output req0_valid, req0_command, req0_a, req0_b,
    output req1_valid, req1_command, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_error, busy
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: logic ops and SIZE+1-bit adds, zero-extended to 2*SIZE.
module alu
  import alu_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic              enable_i,
  input  logic [3:0]        command_i,
  input  logic [SIZE-1:0]   a_i,
  input  logic [SIZE-1:0]   b_i,
  output logic [2*SIZE-1:0] result_o,
  output logic              overflow_o
);

  logic [SIZE:0] sum;

  always_comb begin
    sum        = {1'b0, a_i} + {1'b0, b_i};
    result_o   = {(2*SIZE){1'b0}};
    overflow_o = 1'b0;
    if (enable_i) begin
      case (command_i)
        ALU_AND:  result_o = {{SIZE{1'b0}}, a_i & b_i};
        ALU_OR:   result_o = {{SIZE{1'b0}}, a_i | b_i};
        ALU_XOR:  result_o = {{SIZE{1'b0}}, a_i ^ b_i};
        ALU_NOT:  result_o = {{SIZE{1'b0}}, ~a_i};
        ALU_UADD: begin
          result_o   = {{(SIZE-1){1'b0}}, sum};
          overflow_o = sum[SIZE];
        end
        // Signed overflow: operands agree in sign but the sum does not.
        ALU_SADD: begin
          result_o   = {{(SIZE-1){1'b0}}, sum};
          overflow_o = (a_i[SIZE-1] == b_i[SIZE-1]) && (sum[SIZE-1] != a_i[SIZE-1]);
        end
        default: begin
          result_o   = {(2*SIZE){1'b0}};
          overflow_o = 1'b0;
        end
      endcase
    end else begin
      result_o   = {(2*SIZE){1'b0}};
      overflow_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters;
// one operation in flight, result returned on a tagged response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [SIZE-1:0]   a_q, a_d;
  logic [SIZE-1:0]   b_q, b_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [2*SIZE-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_overflow_q, rsp_overflow_d;
  logic              rsp_error_q, rsp_error_d;

  logic              grant0, grant1, in_idle, cmd_legal, alu_en;
  logic [2*SIZE-1:0] alu_result;
  logic              alu_overflow;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant0    = bus.req0_valid & (~bus.req1_valid | last_grant_q);
    grant1    = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    in_idle   = (state_q == ST_IDLE);
    cmd_legal = (cmd_q <= ALU_LAST_CMD);
    alu_en    = (state_q == ST_EXEC) & cmd_legal;
  end

  alu #(.SIZE(SIZE)) u_alu (
    .enable_i   (alu_en),
    .command_i  (cmd_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .result_o   (alu_result),
    .overflow_o (alu_overflow)
  );

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cmd_d          = cmd_q;
    a_d            = a_q;
    b_d            = b_q;
    id_d           = id_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_error_d    = rsp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0 | grant1) begin
          cmd_d        = grant1 ? bus.req1_command : bus.req0_command;
          a_d          = grant1 ? bus.req1_a : bus.req0_a;
          b_d          = grant1 ? bus.req1_b : bus.req0_b;
          id_d         = grant1;
          last_grant_d = grant1;
          state_d      = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_result_d   = cmd_legal ? alu_result : {(2*SIZE){1'b0}};
        rsp_overflow_d = cmd_legal & alu_overflow;
        rsp_error_d    = ~cmd_legal;
        rsp_id_d       = id_q;
        rsp_valid_d    = 1'b1;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_error_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= 1'b1;
      cmd_q          <= 4'h0;
      a_q            <= {SIZE{1'b0}};
      b_q            <= {SIZE{1'b0}};
      id_q           <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= {(2*SIZE){1'b0}};
      rsp_overflow_q <= 1'b0;
      rsp_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cmd_q          <= cmd_d;
      a_q            <= a_d;
      b_q            <= b_d;
      id_q           <= id_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_error_q    <= rsp_error_d;
    end
  end

  assign bus.req0_ready   = in_idle & grant0;
  assign bus.req1_ready   = in_idle & grant1;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_error    = rsp_error_q;
  assign bus.busy         = ~in_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed ops queue expected responses,
// a negedge monitor pops and compares each accepted response.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int SIZE = 4;

  typedef struct packed {
    logic       id;
    logic [7:0] result;
    logic       ov;
    logic       err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.SIZE(SIZE)) bus ();

  alu_arbiter #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   rdy0_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.req0_ready === 1'b1) rdy0_cnt++;
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got id=%0d result=%0h, want no response", bus.rsp_id, bus.rsp_result);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id",       {31'd0, bus.rsp_id},       {31'd0, mon_e.id});
        check("rsp_result",   {24'd0, bus.rsp_result},   {24'd0, mon_e.result});
        check("rsp_overflow", {31'd0, bus.rsp_overflow}, {31'd0, mon_e.ov});
        check("rsp_error",    {31'd0, bus.rsp_error},    {31'd0, mon_e.err});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic set_req(input logic id, input logic [3:0] cmd, input logic [3:0] a, input logic [3:0] b);
    if (id) begin
      bus.req1_command = cmd;
      bus.req1_a       = a;
      bus.req1_b       = b;
    end else begin
      bus.req0_command = cmd;
      bus.req0_a       = a;
      bus.req0_b       = b;
    end
  endtask

  task automatic push(input logic id, input logic [7:0] res, input logic ov, input logic err);
    rsp_t e;
    e.id     = id;
    e.result = res;
    e.ov     = ov;
    e.err    = err;
    exp_q.push_back(e);
  endtask

  // Holds each requester valid until it has been granted n times.
  task automatic serve(input int n0, input int n1);
    int   guard;
    logic r0, r1;
    guard = 0;
    bus.req0_valid = (n0 > 0);
    bus.req1_valid = (n1 > 0);
    while ((n0 > 0 || n1 > 0) && guard < 100) begin
      @(negedge clk);
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      @(posedge clk);
      #1;
      if (r0) n0--;
      if (r1) n1--;
      bus.req0_valid = (n0 > 0);
      bus.req1_valid = (n1 > 0);
      guard++;
    end
    if (n0 > 0 || n1 > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL serve_timeout: got %0d/%0d grants outstanding, want 0/0", n0, n1);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
  endtask

  // Called just after a handshake edge with rsp_ready high.
  task automatic latency();
    @(negedge clk);
    check("lat_exec_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("lat_exec_busy",  {31'd0, bus.busy},      32'd1);
    @(negedge clk);
    check("lat_resp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    int guard;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_command = 4'h0; bus.req0_a = 4'h0; bus.req0_b = 4'h0;
    bus.req1_valid = 1'b0; bus.req1_command = 4'h0; bus.req1_a = 4'h0; bus.req1_b = 4'h0;
    bus.rsp_ready  = 1'b1;

    @(negedge clk);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid},    32'd0);
    check("rst_rsp_id",    {31'd0, bus.rsp_id},       32'd0);
    check("rst_result",    {24'd0, bus.rsp_result},   32'd0);
    check("rst_overflow",  {31'd0, bus.rsp_overflow}, 32'd0);
    check("rst_error",     {31'd0, bus.rsp_error},    32'd0);
    check("rst_busy",      {31'd0, bus.busy},         32'd0);
    check("rst_ready0",    {31'd0, bus.req0_ready},   32'd0);
    check("rst_ready1",    {31'd0, bus.req1_ready},   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // req0 AND A&5
    set_req(1'b0, ALU_AND, 4'hA, 4'h5);
    push(1'b0, 8'h00, 1'b0, 1'b0);
    c0 = rdy0_cnt;
    serve(1, 0);
    latency();
    idle(2);
    check("ready0_pulses", rdy0_cnt - c0, 32'd1);

    // Simultaneous after reset: req0 first
    do_reset();
    set_req(1'b0, ALU_UADD, 4'hF, 4'h1);
    set_req(1'b1, ALU_SADD, 4'h7, 4'h1);
    push(1'b0, 8'h10, 1'b1, 1'b0);
    push(1'b1, 8'h08, 1'b1, 1'b0);
    serve(1, 1);
    idle(4);

    // Continuous contention alternates 0,1,0,1
    set_req(1'b0, ALU_OR, 4'h5, 4'hA);
    set_req(1'b1, ALU_OR, 4'h5, 4'hA);
    push(1'b0, 8'h0F, 1'b0, 1'b0);
    push(1'b1, 8'h0F, 1'b0, 1'b0);
    push(1'b0, 8'h0F, 1'b0, 1'b0);
    push(1'b1, 8'h0F, 1'b0, 1'b0);
    serve(2, 2);
    idle(4);

    // Back-pressure in RESP with req1 waiting
    bus.rsp_ready = 1'b0;
    set_req(1'b0, ALU_XOR, 4'h7, 4'h3);
    push(1'b0, 8'h04, 1'b0, 1'b0);
    serve(1, 0);
    set_req(1'b1, ALU_AND, 4'hF, 4'hF);
    push(1'b1, 8'h0F, 1'b0, 1'b0);
    bus.req1_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid",  {31'd0, bus.rsp_valid},  32'd1);
      check("hold_result", {24'd0, bus.rsp_result}, 32'h04);
      check("hold_busy",   {31'd0, bus.busy},       32'd1);
      check("hold_ready0", {31'd0, bus.req0_ready}, 32'd0);
      check("hold_ready1", {31'd0, bus.req1_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_busy",   {31'd0, bus.busy},       32'd0);
    check("release_ready1", {31'd0, bus.req1_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    idle(4);

    // Unsupported command
    set_req(1'b1, 4'h9, 4'h3, 4'h4);
    push(1'b1, 8'h00, 1'b0, 1'b1);
    serve(0, 1);
    latency();
    idle(2);

    // Reset during EXEC of req0 must restore last_grant=1
    set_req(1'b0, ALU_UADD, 4'h1, 4'h2);
    serve(1, 0);
    rst = 1'b1;
    #1;
    check("rst0_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst0_busy",      {31'd0, bus.busy},      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(1'b0, ALU_NOT, 4'h3, 4'h0);
    set_req(1'b1, ALU_SADD, 4'h8, 4'hF);
    push(1'b0, 8'h0C, 1'b0, 1'b0);
    push(1'b1, 8'h17, 1'b1, 1'b0);
    serve(1, 1);
    idle(4);

    // Reset during EXEC of req1 SADD 8+F
    set_req(1'b1, ALU_SADD, 4'h8, 4'hF);
    serve(0, 1);
    rst = 1'b1;
    #1;
    check("rst1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst1_busy",      {31'd0, bus.busy},      32'd0);
    check("rst1_rsp_error", {31'd0, bus.rsp_error}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push(1'b0, 8'h0C, 1'b0, 1'b0);
    push(1'b1, 8'h17, 1'b1, 1'b0);
    serve(1, 1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      idle(1);
      guard++;
    end
    idle(2);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
